// File: rtl/chall_r_sampler.sv
// Challenge-point sampler: turns a SHAKE byte stream into T 32-bit extension-field
// points with byte-level (P251) and element-level (base-field point) rejection.
module chall_r_sampler #(
  parameter              FIELD         = "P251",
  parameter              PARAMETER_SET = "L5",
  parameter int unsigned T             = (PARAMETER_SET == "L5") ? 4 : 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic [32*T-1:0]  o_r,
  output logic [7:0]       o_rej_cnt,
  output logic             o_busy,
  output logic             o_done
);

  localparam bit              IS_P251 = (FIELD == "P251");
  localparam int unsigned     KW      = (T > 1) ? $clog2(T) : 1;
  localparam logic [KW-1:0]   K_LAST  = KW'(T - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      b;
  logic [KW-1:0]   k;
  logic [31:0]     e;
  logic [32*T-1:0] r_q;
  logic [7:0]      rej_q;
  logic            accept;
  logic            byte_rej;
  logic            elem_rej;

  assign o_byte_ready = (state == COLLECT);
  assign o_busy       = (state == COLLECT) || (state == CHECK);
  assign o_done       = (state == DONE);
  assign o_r          = r_q;
  assign o_rej_cnt    = rej_q;

  assign accept   = i_byte_valid & o_byte_ready;
  assign byte_rej = IS_P251 && (i_byte >= 8'd251);
  assign elem_rej = (e[31:8] == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = COLLECT;
      COLLECT: if (accept && !byte_rej && (b == 2'd3)) state_nxt = CHECK;
      CHECK:   state_nxt = (!elem_rej && (k == K_LAST)) ? DONE : COLLECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b     <= '0;
      k     <= '0;
      e     <= '0;
      r_q   <= '0;
      rej_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            r_q   <= '0;
            rej_q <= '0;
            b     <= '0;
            k     <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (byte_rej) begin
              if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
            end else begin
              // shifting in MSB-first leaves the first kept byte in e[31:24]
              e <= {e[23:0], i_byte};
              b <= b + 2'd1;
            end
          end
        end
        CHECK: begin
          b <= '0;
          if (elem_rej) begin
            if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
          end else begin
            for (int unsigned i = 0; i < T; i++) begin
              if (k == KW'(i)) r_q[32*i +: 32] <= e;
            end
            if (k != K_LAST) k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
